ram_pair_sweep: RTL and testbench

Parametrised successor to the fixed two-RAM add/subtract sweep. It streams a programmable address range out of two synchronous dual-port RAMs through their read ports, and computes one selectable operation per RAM on each read pair. Results are written back to the same addresses through the write ports. It sits between a control FSM (start/done handshake) and two external RAMs with a 1-cycle registered read.

---
 rtl/ram_pair_sweep_pkg.sv | 19 +
 rtl/ram_pair_sweep_alu.sv | 38 +++
 rtl/ram_pair_sweep.sv | 128 ++++++++++++
 tb/tb_ram_pair_sweep.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pair_sweep_pkg.sv
// Shared types for the two-RAM read/compute/write-back sweep.
// Op codes and the sweep controller states.
package ram_pair_sweep_pkg;

  typedef enum logic [1:0] {
    OP_ADD     = 2'd0,
    OP_SUB     = 2'd1,
    OP_MAX     = 2'd2,
    OP_ABSDIFF = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ram_pair_sweep_alu.sv
// Combinational per-channel operator for the RAM pair sweep.
// Unsigned a/b; ADD/SUB optionally saturate, MAX/ABSDIFF never overflow.
module sweep_alu
  import ram_pair_sweep_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  input  logic              sat,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

  // sum/dif MSB is the carry / borrow out
  always_comb begin
    y = '0;
    unique case (op)
      OP_ADD:
        y = (sat && sum[DATA_W]) ? '1 : sum[DATA_W-1:0];
      OP_SUB:
        y = (sat && dif[DATA_W]) ? '0 : dif[DATA_W-1:0];
      OP_MAX:
        y = (a > b) ? a : b;
      OP_ABSDIFF:
        y = dif[DATA_W] ? (b - a) : dif[DATA_W-1:0];
      default:
        y = '0;
    endcase
  end

endmodule

// File: rtl/ram_pair_sweep.sv
// Streams an address range out of two RAMs, applies one op per RAM,
// and writes the results back two cycles later through the write ports.
module ram_pair_sweep
  import ram_pair_sweep_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              CLOCK_50_I,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [1:0]        op0,
  input  logic [1:0]        op1,
  input  logic              sat,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data0,
  input  logic [DATA_W-1:0] ram_rd_data1,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data0,
  output logic [DATA_W-1:0] ram_wr_data1,
  output logic              ram_wr_en
);

  state_e            state;
  state_e            state_n;
  logic [ADDR_W:0]   rem;
  op_e               op0_q;
  op_e               op1_q;
  logic              sat_q;
  logic              v1;
  logic              v2;
  logic [ADDR_W-1:0] a2;
  logic              launch;
  logic              issue;
  logic [DATA_W-1:0] y0;
  logic [DATA_W-1:0] y1;

  assign launch = (state == S_IDLE) && start;
  assign issue  = (state == S_RUN) && (rem != '0);

  // v1 is cleared on FLUSH entry; its last word drains on the exit edge
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (start)
          state_n = (length == '0) ? S_DONE : S_RUN;
      S_RUN:
        if (rem == '0) state_n = S_FLUSH;
      S_FLUSH:
        if (!v1) state_n = S_DONE;
      S_DONE:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rem         <= '0;
      ram_rd_addr <= '0;
      op0_q       <= OP_ADD;
      op1_q       <= OP_ADD;
      sat_q       <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != S_IDLE);
      done  <= (state == S_DONE);
      if (launch) begin
        op0_q       <= op_e'(op0);
        op1_q       <= op_e'(op1);
        sat_q       <= sat;
        ram_rd_addr <= base_addr;
        rem         <= (length == '0) ? '0 : length - 1'b1;
      end else if (issue) begin
        ram_rd_addr <= ram_rd_addr + 1'b1;
        rem         <= rem - 1'b1;
      end
    end
  end

  sweep_alu #(.DATA_W(DATA_W)) u_alu0 (
    .a   (ram_rd_data0),
    .b   (ram_rd_data1),
    .op  (op0_q),
    .sat (sat_q),
    .y   (y0)
  );

  sweep_alu #(.DATA_W(DATA_W)) u_alu1 (
    .a   (ram_rd_data0),
    .b   (ram_rd_data1),
    .op  (op1_q),
    .sat (sat_q),
    .y   (y1)
  );

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      a2           <= '0;
      ram_wr_en    <= 1'b0;
      ram_wr_addr  <= '0;
      ram_wr_data0 <= '0;
      ram_wr_data1 <= '0;
    end else begin
      v1        <= (launch && (length != '0)) || issue;
      v2        <= v1;
      a2        <= ram_rd_addr;
      ram_wr_en <= v2;
      if (v2) begin
        ram_wr_addr  <= a2;
        ram_wr_data0 <= y0;
        ram_wr_data1 <= y1;
      end
    end
  end

endmodule

// File: tb/tb_ram_pair_sweep.sv
// Randomised scoreboard bench for ram_pair_sweep with two modelled RAMs.
// Expected writes are queued at start and popped by a write monitor.
module tb_ram_pair_sweep;

  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;
  localparam int MAXV  = (1 << DW) - 1;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [1:0]    op0;
  logic [1:0]    op1;
  logic          sat;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data0;
  logic [DW-1:0] ram_rd_data1;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data0;
  logic [DW-1:0] ram_wr_data1;
  logic          ram_wr_en;

  ram_pair_sweep #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLOCK_50_I   (clk),
    .resetn       (resetn),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .op0          (op0),
    .op1          (op1),
    .sat          (sat),
    .busy         (busy),
    .done         (done),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data0 (ram_rd_data0),
    .ram_rd_data1 (ram_rd_data1),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data0 (ram_wr_data0),
    .ram_wr_data1 (ram_wr_data1),
    .ram_wr_en    (ram_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int d0;
    int d1;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   tests    = 0;
  int   fails    = 0;
  int   wr_count = 0;

  logic [DW-1:0] m0[DEPTH];
  logic [DW-1:0] m1[DEPTH];
  logic          fill_req;
  int            fill_kind;
  int            fill_a;
  int            fill_b;

  // RAM pair: registered read, write on wr_en, bulk fill for setup
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < DEPTH; i++) begin
        case (fill_kind)
          0: begin m0[i] <= DW'(i);      m1[i] <= DW'(fill_b); end
          1: begin m0[i] <= DW'(fill_a); m1[i] <= DW'(fill_b); end
          default: begin
            m0[i] <= DW'($urandom);
            m1[i] <= DW'($urandom);
          end
        endcase
      end
    end else if (ram_wr_en) begin
      m0[ram_wr_addr] <= ram_wr_data0;
      m1[ram_wr_addr] <= ram_wr_data1;
    end
    ram_rd_data0 <= m0[ram_rd_addr];
    ram_rd_data1 <= m1[ram_rd_addr];
  end

  function automatic int ref_op(int op, bit s, int a, int b);
    int r;
    case (op)
      0: begin
        r = a + b;
        r = s ? ((r > MAXV) ? MAXV : r) : (r % (MAXV + 1));
      end
      1: begin
        r = a - b;
        r = s ? ((r < 0) ? 0 : r) : ((r + MAXV + 1) % (MAXV + 1));
      end
      2: r = (a > b) ? a : b;
      default: r = (a > b) ? (a - b) : (b - a);
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (resetn && ram_wr_en) begin
      wr_count++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected addr=%0d d0=%0d d1=%0d",
                 ram_wr_addr, ram_wr_data0, ram_wr_data1);
      end else begin
        me = q.pop_front();
        if (int'(ram_wr_addr) != me.addr ||
            int'(ram_wr_data0) != me.d0 ||
            int'(ram_wr_data1) != me.d1) begin
          fails++;
          $display("FAIL wr_data got a=%0d d0=%0d d1=%0d exp a=%0d d0=%0d d1=%0d",
                   ram_wr_addr, ram_wr_data0, ram_wr_data1,
                   me.addr, me.d0, me.d1);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_addr"}, ram_rd_addr, 0);
    chk({tag, "_wr_addr"}, ram_wr_addr, 0);
    chk({tag, "_wr_d0"}, ram_wr_data0, 0);
    chk({tag, "_wr_d1"}, ram_wr_data1, 0);
    chk({tag, "_wr_en"}, ram_wr_en, 0);
  endtask

  task automatic fill(input int kind, input int a, input int b);
    @(negedge clk);
    fill_kind = kind;
    fill_a    = a;
    fill_b    = b;
    fill_req  = 1'b1;
    @(negedge clk);
    fill_req  = 1'b0;
  endtask

  task automatic run_sweep(input int b, input int l, input int o0,
                           input int o1, input bit s,
                           input int abort_at, input bit poke);
    int  n;
    int  w0;
    bit  seen;
    @(negedge clk);
    for (int i = 0; i < l; i++) begin
      int a;
      a = (b + i) % DEPTH;
      q.push_back('{a, ref_op(o0, s, m0[a], m1[a]),
                    ref_op(o1, s, m0[a], m1[a])});
    end
    w0        = wr_count;
    base_addr = AW'(b);
    length    = (AW+1)'(l);
    op0       = 2'(o0);
    op1       = 2'(o1);
    sat       = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (l > 0) begin
      chk("busy_e0", busy, 1);
      chk("rd_addr_e0", ram_rd_addr, b);
    end
    base_addr = AW'($urandom);
    length    = (AW+1)'($urandom);
    op0       = 2'($urandom);
    op1       = 2'($urandom);
    sat       = 1'($urandom);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < l + 20) begin
      @(posedge clk);
      #1;
      n++;
      start = (poke && n == 5);
      if (abort_at > 0 && n == abort_at) begin
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk_zero_outputs("abort");
        chk("abort_writes", wr_count - w0, 4);
        q.delete();
        @(negedge clk);
        resetn = 1'b1;
        return;
      end
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    chk("done_edge", n, (l == 0) ? 1 : l + 2);
    chk("busy_at_done", busy, 0);
    chk("writes", wr_count - w0, l);
    chk("q_empty", q.size(), 0);
    q.delete();
    @(posedge clk);
    #1;
    chk("done_pulse", done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int s1;
    int s2;
    int s3;
    resetn    = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    op0       = '0;
    op1       = '0;
    sat       = 1'b0;
    fill_req  = 1'b0;
    fill_kind = 0;
    fill_a    = 0;
    fill_b    = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;

    // full-depth wrap sweep: RAM0 = i+1, RAM1 = i-1
    fill(0, 0, 1);
    run_sweep(0, 512, 0, 1, 1'b0, 0, 1'b0);
    chk("t1_m0_5", m0[5], 6);
    chk("t1_m1_0", m1[0], 255);
    chk("t1_m0_300", m0[300], 45);
    chk("t1_m1_300", m1[300], 43);

    // saturation both directions
    fill(1, 200, 100);
    run_sweep(37, 4, 0, 1, 1'b1, 0, 1'b0);
    chk("t2_m0", m0[37], 255);
    chk("t2_m1", m1[40], 100);
    fill(1, 100, 200);
    run_sweep(37, 4, 0, 1, 1'b1, 0, 1'b0);
    chk("t2s_m1", m1[38], 0);
    chk("t2s_m0", m0[38], 255);

    // top-of-range wrap with MAX / ABSDIFF
    fill(2, 0, 0);
    @(negedge clk);
    s0 = m0[2];
    s1 = m1[2];
    s2 = m0[509];
    run_sweep(510, 4, 2, 3, 1'b0, 0, 1'b0);
    chk("t3_m0_2", m0[2], s0);
    chk("t3_m1_2", m1[2], s1);
    chk("t3_m0_509", m0[509], s2);

    // empty sweep, then start poked while busy
    run_sweep(100, 0, 0, 0, 1'b0, 0, 1'b0);
    run_sweep(200, 16, 3, 2, 1'b1, 0, 1'b1);

    // reset mid-sweep, then a clean rerun
    fill(2, 0, 0);
    @(negedge clk);
    s0 = m0[54];
    s1 = m1[54];
    s3 = m0[60];
    run_sweep(50, 32, 0, 1, 1'b0, 5, 1'b0);
    chk("t5_m0_54", m0[54], s0);
    chk("t5_m1_54", m1[54], s1);
    chk("t5_m0_60", m0[60], s3);
    run_sweep(50, 32, 1, 0, 1'b1, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      fill(2, 0, 0);
      run_sweep($urandom_range(0, DEPTH - 1), $urandom_range(1, 64),
                $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
